// File: rtl/sd_spi_cmd_engine.sv
// sd_spi_cmd_engine
// SPI-mode SD command engine. Derives SCK from input_clk, optionally sends the
// power-up preamble (CS high, MOSI high), then sends one 48-bit command frame
// with a computed CRC7. It then collects an R1 byte, plus 32 trailing bits for
// R3/R7 replies, and resends the command when the response wait times out.
//
// Ports:
//   input_clk    system clock, rising edge
//   resend       synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_index, cmd_arg   command fields, captured on accept
//   cmd_init     run the preamble before the command
//   cmd_long     capture 32 bits after R1
//   busy         engine not in IDLE
//   resp_valid   one-cycle pulse with the final result
//   resp_r1, resp_data, resp_timeout, retries_used  result fields
//   sd_sck, CS_bit, MOSI_bit, MISO_bit  SPI mode-0 bus
module sd_spi_cmd_engine #(
    parameter int CLK_DIV     = 50,
    parameter int INIT_CYCLES = 80,
    parameter int NCR_MAX     = 8,
    parameter int MAX_RETRY   = 3,
    parameter int TAIL_CYCLES = 8
) (
    input  logic        input_clk,
    input  logic        resend,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        cmd_init,
    input  logic        cmd_long,
    output logic        busy,
    output logic        resp_valid,
    output logic [7:0]  resp_r1,
    output logic [31:0] resp_data,
    output logic        resp_timeout,
    output logic [3:0]  retries_used,
    output logic        sd_sck,
    output logic        CS_bit,
    output logic        MOSI_bit,
    input  logic        MISO_bit
);

    localparam int               DIV_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0]      PRE_LAST  = 16'(INIT_CYCLES - 1);
    localparam logic [15:0]      WAIT_LAST = 16'(NCR_MAX * 8 - 1);
    // TAIL counts falls: the first fall closes the last data cycle, the
    // remaining TAIL_CYCLES falls are full cycles with CS high.
    localparam logic [15:0]      TAIL_LAST = 16'(TAIL_CYCLES);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE, PRE, SEND, WAIT, R1, RDAT, TAIL, DONE
    } state_t;

    // CRC7, polynomial x^7 + x^3 + 1, register starts at zero.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] head;
        head = {2'b01, idx, arg};
        return {head, crc7(head), 1'b1};
    endfunction

    state_t             state_q;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic               sck_q, cs_q, mosi_q;
    logic [47:0]        frame_q, frame_in;
    logic [46:0]        sh_q;
    logic [15:0]        cyc_q;
    logic [7:0]         r1_q;
    logic [31:0]        data_q;
    logic               long_q, to_q;
    logic [3:0]         retries_q;
    logic               rv_q, resp_to_q;
    logic [7:0]         resp_r1_q;
    logic [31:0]        resp_data_q;
    logic               tick, rise_evt, fall_evt;

    // SCK divider runs only while a transaction is on the bus.
    always_comb begin
        tick = 1'b0;
        if (state_q != IDLE && state_q != DONE && cnt_q == DIV_LAST) tick = 1'b1;
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        rise_evt = tick & ~sck_q;
        fall_evt = tick & sck_q;
        frame_in = build_frame(cmd_index, cmd_arg);
    end

    always_ff @(posedge input_clk) begin
        if (!resend) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sck_q       <= 1'b0;
            cs_q        <= 1'b1;
            mosi_q      <= 1'b1;
            frame_q     <= '0;
            sh_q        <= '0;
            cyc_q       <= '0;
            r1_q        <= 8'hFF;
            data_q      <= '0;
            long_q      <= 1'b0;
            to_q        <= 1'b0;
            retries_q   <= '0;
            rv_q        <= 1'b0;
            resp_to_q   <= 1'b0;
            resp_r1_q   <= 8'hFF;
            resp_data_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (tick) sck_q <= ~sck_q;
            rv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    sck_q <= 1'b0;
                    if (cmd_valid) begin
                        frame_q   <= frame_in;
                        long_q    <= cmd_long;
                        retries_q <= '0;
                        cyc_q     <= '0;
                        if (cmd_init) begin
                            state_q <= PRE;
                            cs_q    <= 1'b1;
                            mosi_q  <= 1'b1;
                        end else begin
                            // First bit goes out half a period before the first rise.
                            state_q <= SEND;
                            cs_q    <= 1'b0;
                            mosi_q  <= frame_in[47];
                            sh_q    <= frame_in[46:0];
                        end
                    end
                end
                PRE: begin
                    if (fall_evt) begin
                        if (cyc_q == PRE_LAST) begin
                            state_q <= SEND;
                            cs_q    <= 1'b0;
                            mosi_q  <= frame_q[47];
                            sh_q    <= frame_q[46:0];
                            cyc_q   <= '0;
                        end else begin
                            cyc_q <= cyc_q + 16'd1;
                        end
                    end
                end
                SEND: begin
                    if (fall_evt) begin
                        if (cyc_q == 16'd47) begin
                            state_q <= WAIT;
                            mosi_q  <= 1'b1;
                            cyc_q   <= '0;
                        end else begin
                            mosi_q <= sh_q[46];
                            sh_q   <= {sh_q[45:0], 1'b1};
                            cyc_q  <= cyc_q + 16'd1;
                        end
                    end
                end
                WAIT: begin
                    if (rise_evt) begin
                        if (!MISO_bit) begin
                            // This zero is R1 bit 7.
                            state_q <= R1;
                            r1_q    <= {r1_q[6:0], MISO_bit};
                            data_q  <= '0;
                            to_q    <= 1'b0;
                            cyc_q   <= 16'd1;
                        end else if (cyc_q == WAIT_LAST) begin
                            state_q <= TAIL;
                            cs_q    <= 1'b1;
                            to_q    <= 1'b1;
                            cyc_q   <= '0;
                        end else begin
                            cyc_q <= cyc_q + 16'd1;
                        end
                    end
                end
                R1: begin
                    if (rise_evt) begin
                        r1_q <= {r1_q[6:0], MISO_bit};
                        if (cyc_q == 16'd7) begin
                            cyc_q <= '0;
                            if (long_q) begin
                                state_q <= RDAT;
                            end else begin
                                state_q <= TAIL;
                                cs_q    <= 1'b1;
                            end
                        end else begin
                            cyc_q <= cyc_q + 16'd1;
                        end
                    end
                end
                RDAT: begin
                    if (rise_evt) begin
                        data_q <= {data_q[30:0], MISO_bit};
                        if (cyc_q == 16'd31) begin
                            state_q <= TAIL;
                            cs_q    <= 1'b1;
                            cyc_q   <= '0;
                        end else begin
                            cyc_q <= cyc_q + 16'd1;
                        end
                    end
                end
                TAIL: begin
                    if (fall_evt) begin
                        if (cyc_q == TAIL_LAST) begin
                            cyc_q <= '0;
                            if (to_q && retries_q < RETRY_MAX) begin
                                // Resend without a preamble.
                                retries_q <= retries_q + 4'd1;
                                state_q   <= SEND;
                                cs_q      <= 1'b0;
                                mosi_q    <= frame_q[47];
                                sh_q      <= frame_q[46:0];
                            end else begin
                                state_q     <= DONE;
                                rv_q        <= 1'b1;
                                resp_to_q   <= to_q;
                                resp_r1_q   <= to_q ? 8'hFF : r1_q;
                                resp_data_q <= (to_q || !long_q) ? 32'h0 : data_q;
                            end
                        end else begin
                            cyc_q <= cyc_q + 16'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign resp_valid   = rv_q;
    assign resp_r1      = resp_r1_q;
    assign resp_data    = resp_data_q;
    assign resp_timeout = resp_to_q;
    assign retries_used = retries_q;
    assign sd_sck       = sck_q;
    assign CS_bit       = cs_q;
    assign MOSI_bit     = mosi_q;

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
module tb_sd_spi_cmd_engine;

    localparam int CD   = 2;
    localparam int INIT = 80;
    localparam int NCR  = 8;
    localparam int MR   = 3;
    localparam int TAIL = 8;
    localparam int PER  = 2 * CD;
    localparam int WAIT_LIMIT = 6000;

    logic        clk = 1'b0;
    logic        resend = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        cmd_init = 1'b0;
    logic        cmd_long = 1'b0;
    logic        busy;
    logic        resp_valid;
    logic [7:0]  resp_r1;
    logic [31:0] resp_data;
    logic        resp_timeout;
    logic [3:0]  retries_used;
    logic        sd_sck;
    logic        CS_bit;
    logic        MOSI_bit;
    logic        MISO_bit = 1'b1;

    sd_spi_cmd_engine #(
        .CLK_DIV(CD), .INIT_CYCLES(INIT), .NCR_MAX(NCR), .MAX_RETRY(MR), .TAIL_CYCLES(TAIL)
    ) dut (
        .input_clk(clk), .resend(resend), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_init(cmd_init), .cmd_long(cmd_long),
        .busy(busy), .resp_valid(resp_valid), .resp_r1(resp_r1), .resp_data(resp_data),
        .resp_timeout(resp_timeout), .retries_used(retries_used), .sd_sck(sd_sck),
        .CS_bit(CS_bit), .MOSI_bit(MOSI_bit), .MISO_bit(MISO_bit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  r1;
        logic [31:0] data;
        logic        to;
        logic [3:0]  retries;
        int          lat;
        int          acc;
        int          hi;
    } exp_t;

    typedef struct {
        logic        to;
        int          ncr;
        logic [7:0]  r1;
        logic [31:0] data;
        logic        lng;
    } plan_t;

    exp_t        sbq[$];
    plan_t       planq[$];
    logic [47:0] frameq[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference frame: CRC7 as the remainder of polynomial long division.
    function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        logic [46:0] v;
        h = {2'b01, idx, arg};
        v = {h, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v = v ^ (47'h89 << (i - 7));
        return {h, v[6:0], 1'b1};
    endfunction

    // Card model and response monitor.
    logic        prev_sck = 1'b0;
    logic        prev_cs = 1'b1;
    int          rx_cnt = 0;
    logic [47:0] cap = '0;
    logic        bitq[$];
    int          hi_rises = 0;
    logic        mosi_bad = 1'b0;
    exp_t        me;
    plan_t       mp;
    logic [47:0] mf;
    int          dl;

    always @(negedge clk) begin
        if (CS_bit && !prev_cs) begin
            if (rx_cnt == 48) begin
                if (frameq.size() == 0) begin
                    check("frame_unexpected", 64'(cap), 64'h0);
                end else begin
                    mf = frameq.pop_front();
                    check("frame", 64'(cap), 64'(mf));
                end
            end else if (rx_cnt != 0) begin
                // aborted transaction: forget its bus history
                hi_rises = 0;
                mosi_bad = 1'b0;
            end
            rx_cnt = 0;
            bitq.delete();
            MISO_bit = 1'b1;
        end
        if (sd_sck && !prev_sck && CS_bit && prev_cs) begin
            hi_rises++;
            if (!MOSI_bit) mosi_bad = 1'b1;
        end
        if (sd_sck && !prev_sck && !CS_bit && rx_cnt < 48) begin
            cap = {cap[46:0], MOSI_bit};
            rx_cnt++;
            if (rx_cnt == 48) begin
                if (planq.size() > 0) begin
                    mp = planq.pop_front();
                    if (!mp.to) begin
                        for (int i = 0; i < mp.ncr; i++) bitq.push_back(1'b1);
                        for (int i = 7; i >= 0; i--) bitq.push_back(mp.r1[i]);
                        if (mp.lng) for (int i = 31; i >= 0; i--) bitq.push_back(mp.data[i]);
                    end
                end
            end
        end
        if (!sd_sck && prev_sck && !CS_bit && rx_cnt == 48)
            MISO_bit = (bitq.size() > 0) ? bitq.pop_front() : 1'b1;
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                check("resp_unexpected", 64'(resp_valid), 64'h0);
            end else begin
                me = sbq.pop_front();
                check("resp_r1", 64'(resp_r1), 64'(me.r1));
                check("resp_data", 64'(resp_data), 64'(me.data));
                check("resp_timeout", 64'(resp_timeout), 64'(me.to));
                check("retries_used", 64'(retries_used), 64'(me.retries));
                check("cs_high_sck_cycles", 64'(hi_rises), 64'(me.hi));
                check("mosi_high_when_cs_high", 64'(mosi_bad), 64'h0);
                dl = cyc_cnt - me.acc;
                n_total++;
                if (dl >= me.lat && dl <= me.lat + 2) n_pass++;
                else $display("FAIL latency: got %0d expected %0d..%0d", dl, me.lat, me.lat + 2);
            end
            hi_rises = 0;
            mosi_bad = 1'b0;
        end
        prev_sck = sd_sck;
        prev_cs  = CS_bit;
    end

    task automatic wait_idle();
        int wt = 0;
        while (!cmd_ready && wt < WAIT_LIMIT) begin
            @(negedge clk);
            wt++;
        end
        if (!cmd_ready) check("wait_idle", 64'(cmd_ready), 64'h1);
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit init,
                           input bit lng, input int n_to, input int ncr,
                           input logic [7:0] r1, input logic [31:0] data, input bit hold);
        exp_t  e;
        plan_t p;
        bit    succ;
        int    nto, att, wt, bad;
        wait_idle();
        succ = (n_to <= MR);
        nto  = succ ? n_to : MR + 1;
        att  = succ ? n_to + 1 : nto;
        for (int i = 0; i < att; i++) begin
            p.to = (i < nto); p.ncr = ncr; p.r1 = r1; p.data = data; p.lng = lng;
            planq.push_back(p);
            frameq.push_back(model_frame(idx, arg));
        end
        e.r1      = succ ? r1 : 8'hFF;
        e.data    = (succ && lng) ? data : 32'h0;
        e.to      = !succ;
        e.retries = 4'(att - 1);
        e.hi      = (init ? INIT : 0) + att * TAIL;
        e.lat     = (init ? PER * INIT : 0) + nto * PER * (48 + NCR * 8 + TAIL)
                  + (succ ? PER * (48 + ncr + 8 + (lng ? 32 : 0) + TAIL) : 0);
        e.acc     = cyc_cnt + 1;
        sbq.push_back(e);
        cmd_index = idx; cmd_arg = arg; cmd_init = init; cmd_long = lng;
        cmd_valid = 1'b1;
        wt = 0; bad = 0;
        if (!hold) begin
            @(negedge clk);
            wt++;
            cmd_valid = 1'b0;
            cmd_arg   = $urandom;
            cmd_index = 6'($urandom);
        end
        while (!resp_valid && wt < WAIT_LIMIT) begin
            @(negedge clk);
            wt++;
            if (hold && !resp_valid) begin
                if (cmd_ready || !busy) bad++;
                cmd_arg   = $urandom;
                cmd_index = 6'($urandom);
                cmd_long  = 1'($urandom);
            end
        end
        cmd_valid = 1'b0;
        if (!resp_valid) check("resp_wait_bound", 64'(resp_valid), 64'h1);
        if (hold) check("ready_low_while_busy", 64'(bad), 64'h0);
    endtask

    initial begin
        int wt;
        resend = 1'b0;
        repeat (3) @(negedge clk);
        resend = 1'b1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_sck", 64'(sd_sck), 64'h0);
        check("rst_cs", 64'(CS_bit), 64'h1);
        check("rst_mosi", 64'(MOSI_bit), 64'h1);
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_resp_r1", 64'(resp_r1), 64'hFF);
        check("rst_resp_data", 64'(resp_data), 64'h0);
        check("rst_resp_timeout", 64'(resp_timeout), 64'h0);
        check("rst_retries", 64'(retries_used), 64'h0);

        // CMD0 with preamble, R1 = 01 after eight idle bits
        run_cmd(6'd0, 32'h0, 1'b1, 1'b0, 0, 8, 8'h01, 32'h0, 1'b0);
        // CMD8 long response
        run_cmd(6'd8, 32'h1AA, 1'b0, 1'b1, 0, int'($urandom_range(0, 10)), 8'h01, 32'h000001AA, 1'b0);
        // every attempt times out
        run_cmd(6'd17, $urandom, 1'b0, 1'b0, MR + 1, 0, 8'h00, 32'h0, 1'b0);
        // first attempt times out, second answers 00; one preamble only
        run_cmd(6'd41, 32'h40000000, 1'b1, 1'b0, 1, 3, 8'h00, 32'h0, 1'b0);

        // reset in the middle of SEND
        wait_idle();
        cmd_index = 6'd55; cmd_arg = $urandom; cmd_init = 1'b0; cmd_long = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wt = 0;
        while (rx_cnt < 20 && wt < WAIT_LIMIT) begin
            @(negedge clk);
            wt++;
        end
        check("abort_reached_bit20", 64'(rx_cnt >= 20), 64'h1);
        resend = 1'b0;
        @(negedge clk);
        resend = 1'b1;
        check("abort_cs", 64'(CS_bit), 64'h1);
        check("abort_sck", 64'(sd_sck), 64'h0);
        check("abort_mosi", 64'(MOSI_bit), 64'h1);
        check("abort_cmd_ready", 64'(cmd_ready), 64'h1);
        check("abort_resp_valid", 64'(resp_valid), 64'h0);
        repeat (4) @(negedge clk);
        run_cmd(6'd58, 32'h0, 1'b0, 1'b1, 0, 2, 8'h00, 32'hC0FF8000, 1'b0);

        // cmd_valid held with changing inputs while busy
        run_cmd(6'd13, $urandom, 1'b0, 1'b0, 0, 5, 8'h05, 32'h0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            int n_to;
            n_to = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_cmd(6'($urandom), $urandom, ($urandom_range(0, 3) == 0), 1'($urandom),
                    n_to, int'($urandom_range(0, 20)), 8'($urandom) & 8'h7F, $urandom, 1'b0);
        end

        repeat (10) @(negedge clk);
        check("sb_drained", 64'(sbq.size()), 64'h0);
        check("frames_drained", 64'(frameq.size()), 64'h0);
        check("plans_drained", 64'(planq.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sd_spi_cmd_engine.md
Name: sd_spi_cmd_engine

Overview:
Parametrised SPI-mode SD command engine. It generates its own SCK from the single system clock and optionally emits the power-up preamble (CS high, MOSI high). It sends any 48-bit command frame with internally computed CRC7, captures an R1 response or a long R1+32-bit response (R3/R7), and retries on timeout. This is the generalised successor to the CMD0-only init sequencer. The card-init controller drives it for CMD0/CMD8/ACMD41/CMD58 and, later, for data commands.

Parameters:
CLK_DIV, 50, input_clk cycles per SCK half-period (must be 2 or more; 50 gives 250 kHz from 25 MHz)
INIT_CYCLES, 80, SCK cycles in the preamble (must be 74 or more)
NCR_MAX, 8, maximum response wait in bytes; wait limit is NCR_MAX*8 SCK cycles
MAX_RETRY, 3, resends after a timeout before reporting failure (0 to 15)
TAIL_CYCLES, 8, SCK cycles with CS high after each transaction

Ports:
input_clk  in  1  system clock; all logic on its rising edge
resend  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high
cmd_index  in  6  command index
cmd_arg  in  32  command argument
cmd_init  in  1  run the preamble before this command
cmd_long  in  1  capture 32 data bits after R1
busy  out  1  high whenever the engine is not in IDLE
resp_valid  out  1  one-cycle pulse when the result is final
resp_r1  out  8  captured R1 byte; 8'hFF on timeout
resp_data  out  32  captured trailing bits; 0 when cmd_long=0
resp_timeout  out  1  valid with resp_valid; high means every attempt timed out
retries_used  out  4  number of resends used, valid with resp_valid
sd_sck  out  1  SPI clock, idles low (mode 0)
CS_bit  out  1  chip select, active low
MOSI_bit  out  1  serial data to the card
MISO_bit  in  1  serial data from the card

Behaviour:
- Reset (resend=0 at a clock edge), also when it arrives mid-transaction: state IDLE, sd_sck=0, CS_bit=1, MOSI_bit=1, resp_valid=0, resp_r1=8'hFF, resp_data=0, resp_timeout=0, retries_used=0, cmd_ready=1, busy=0. Any in-flight transaction is abandoned with no resp_valid.
- SCK generation:
  - Divider counts 0..CLK_DIV-1 and toggles sd_sck at terminal count, only outside IDLE/DONE.
  - A rise event (sd_sck 0->1) samples MISO_bit.
  - A fall event (sd_sck 1->0) advances MOSI_bit.
  - sd_sck is always low when entering or leaving IDLE.
- Command acceptance: the engine registers cmd_index, cmd_arg, cmd_init and cmd_long. Later input changes are ignored.
- Frame: {2'b01, cmd_index, cmd_arg, crc7, 1'b1}, 48 bits, sent MSB first.
  - crc7 uses polynomial x^7+x^3+1 over the first 40 bits, with the register initialised to 0.
  - Check values: CMD0/arg 0 gives last byte 8'h95; CMD8/arg 32'h1AA gives 8'h87.
- States:
  - IDLE:
    - On accept, go to PRE if cmd_init=1, otherwise to SEND.
    - Clear retries_used.
  - PRE: CS=1, MOSI=1 for INIT_CYCLES full SCK cycles, then go to SEND.
  - SEND:
    - CS=0. Bit 47 is on MOSI one half-period before the first rise.
    - Each following fall presents the next bit.
    - After the 48th fall, go to WAIT with MOSI=1.
  - WAIT:
    - CS=0, MOSI=1. Sample each rise.
    - The first sampled 0 is R1 bit 7; go to R1.
    - If NCR_MAX*8 rises pass with no 0, it is a timeout: go to TAIL with the retry flag set.
  - R1: shift in 7 more bits, MSB first, for 8 bits in total including the start 0. Then go to RDAT if cmd_long=1, otherwise to TAIL.
  - RDAT: shift in 32 bits, MSB first, into resp_data.
  - TAIL: CS=1, MOSI=1 for TAIL_CYCLES SCK cycles. Then:
    - if this was a timeout and retries_used < MAX_RETRY: increment retries_used and go to SEND (no preamble);
    - otherwise go to DONE.
  - DONE:
    - Pulse resp_valid for one cycle.
    - resp_timeout=1 only if the final attempt timed out; in that case resp_r1=8'hFF and resp_data=0.
    - Next cycle go to IDLE, where cmd_ready=1. No accept is possible in the DONE cycle.
- resp_r1, resp_data and resp_timeout hold their values until the next DONE or reset. They are updated at DONE only.
- Latency from accept to resp_valid with no timeout:
  - 2*CLK_DIV*(48 + Ncr + 8 + 32*cmd_long + TAIL_CYCLES) input_clk cycles, plus 2*CLK_DIV*INIT_CYCLES if cmd_init=1, plus at most 2 cycles of overhead.
  - Ncr is the number of 1-bits seen in WAIT.
- MISO is ignored outside WAIT, R1 and RDAT.

Test Plan:
- CLK_DIV=2, cmd_init=1, CMD0/arg 0; card model returns 8'h01 after Ncr=8 bits. Required:
  - 80 SCK cycles with CS=1 and MOSI=1;
  - then MOSI frame 48'h400000000095 while CS=0;
  - resp_valid with resp_r1=8'h01, resp_timeout=0, retries_used=0.
- CMD8/arg 32'h1AA with cmd_long=1; model returns 8'h01 then 32'h000001AA. Required: frame 48'h48000001AA87, resp_r1=8'h01, resp_data=32'h000001AA.
- MISO held at 1, MAX_RETRY=3. Required:
  - four 48-bit frames, each followed by 64 wait cycles and 8 tail cycles;
  - then resp_timeout=1, resp_r1=8'hFF, retries_used=3.
- Model times out on the first attempt and answers 8'h00 on the second. Required: resp_timeout=0, retries_used=1, resp_r1=8'h00; only one preamble is sent.
- resend=0 pulsed for one cycle at bit 20 of SEND. Required:
  - next cycle CS=1, sd_sck=0, MOSI=1, cmd_ready=1, no resp_valid;
  - a fresh command afterwards completes normally.
- cmd_valid held high with changing cmd_arg during busy. Required: no second accept until IDLE, frames use only the argument captured at accept, and cmd_ready=0 throughout.
